// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI definitions for the read path: burst type codes, response codes,
// the read-master state encoding and a constant-friendly clog2 helper used to
// derive arsize and address alignment from the bus width.
// No ports (package).
// -----------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE = 2'b00,
        RD_ADDR = 2'b01,
        RD_DATA = 2'b10,
        RD_DONE = 2'b11
    } rdState_t;

    // Smallest n with 2**n >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_rd_out_reg.sv
// -----------------------------------------------------------------------------
// axi_rd_out_reg
// Single-entry valid/ready holding register between the AXI R channel and the
// downstream stream port. It produces rready so that a new beat can be taken
// whenever the slot is empty or is being emptied in the same cycle, which
// gives one beat per cycle when downstream is always ready.
//
// Ports:
//   aclk, aresetn  clock, synchronous active-low reset
//   i_enable       master is in its data phase (rready forced low otherwise)
//   i_data/i_last  beat payload and end-of-burst flag to capture
//   i_valid        R channel valid (rvalid)
//   i_ready        downstream ready (out_ready)
//   o_rready       R channel ready
//   o_accept       R handshake happening this cycle
//   o_data/o_last/o_valid  registered stream output
// -----------------------------------------------------------------------------
module axi_rd_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_valid,
    input  logic                  i_ready,
    output logic                  o_rready,
    output logic                  o_accept,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_valid
);

    logic                  r_valid;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_data;

    // The slot can take a new beat if it is empty, or if its current beat
    // leaves this cycle; this is what keeps back-to-back throughput at 1/cycle.
    always_comb begin
        o_rready = i_enable && (!r_valid || i_ready);
        o_accept = o_rready && i_valid;
    end

    // Capture a beat on the R handshake; otherwise drop valid once the
    // downstream side has taken the held beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (o_accept) begin
            r_valid <= 1'b1;
            r_last  <= i_last;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_valid = r_valid;

endmodule

// File: rtl/axi_read_master.sv
// -----------------------------------------------------------------------------
// axi_read_master
// AXI4 read initiator: takes one {address, length} command, issues a single
// INCR burst on AR, collects the R beats into a one-entry output register and
// reports a per-command completion status on done_valid/done_resp.
//
// Ports:
//   aclk, aresetn                      clock, synchronous active-low reset
//   cmd_addr, cmd_len, cmd_valid/ready read command (len = beats - 1)
//   out_data, out_last, out_valid/ready  beat stream to downstream
//   done_valid, done_resp              one-cycle completion pulse and status
//   araddr, arlen, arsize, arburst, arvalid/arready   AXI AR channel
//   rdata, rresp, rlast, rvalid/rready                AXI R channel
//
// Build option: define AXI_READ_MASTER_TIMEOUT_EN to add an idle watchdog
// that abandons a stalled burst after TIMEOUT_CYCLES and reports DECERR.
// -----------------------------------------------------------------------------
module axi_read_master
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done_valid,
    output logic [1:0]               done_resp,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready
);

    localparam int                       ALIGN_BITS = clog2(STROBE_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'((1 << ALIGN_BITS) - 1);
    localparam logic [2:0]               AR_SIZE    = 3'(ALIGN_BITS);

    rdState_t                 r_state;
    rdState_t                 w_nextState;
    logic                     r_arvalid;
    logic [ADDRESS_WIDTH-1:0] r_araddr;
    logic [7:0]               r_arlen;
    logic [8:0]               r_beatsRemaining;
    logic [1:0]               r_status;

    logic w_cmdAccept;
    logic w_arHandshake;
    logic w_rAccept;
    logic w_dataPhase;
    logic w_finalBeat;
    logic w_rlastBad;
    logic w_timeout;

    assign w_cmdAccept   = cmd_ready && cmd_valid;
    assign w_arHandshake = r_arvalid && arready;
    assign w_dataPhase   = (r_state == RD_DATA);
    assign w_finalBeat   = (r_beatsRemaining == 9'd1);
    assign w_rlastBad    = (rlast != w_finalBeat);

`ifdef AXI_READ_MASTER_TIMEOUT_EN
    localparam int TIMER_WIDTH = (clog2(TIMEOUT_CYCLES + 1) > 8) ? clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TIMER_WIDTH-1:0] r_idleTimer;
    logic                   w_busy;
    logic                   w_anyHandshake;

    assign w_busy         = (r_state == RD_ADDR) || (r_state == RD_DATA);
    assign w_anyHandshake = w_arHandshake || w_rAccept;
    assign w_timeout      = w_busy && !w_anyHandshake && (r_idleTimer == TIMER_WIDTH'(TIMEOUT_CYCLES));

    // Count consecutive busy cycles without progress on either channel;
    // any handshake (or leaving the busy states) restarts the count.
    always_ff @(posedge aclk) begin
        if (!aresetn || !w_busy || w_anyHandshake) begin
            r_idleTimer <= '0;
        end else begin
            r_idleTimer <= r_idleTimer + 1'b1;
        end
    end
`else
    logic w_unusedTimeout;

    assign w_timeout       = 1'b0;
    assign w_unusedTimeout = (TIMEOUT_CYCLES != 0);
`endif

    // State register for the command / address / data / done sequence.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and the per-state handshake outputs. The done status is
    // only presented during the single DONE cycle.
    always_comb begin
        w_nextState = r_state;
        cmd_ready   = 1'b0;
        done_valid  = 1'b0;
        done_resp   = RESP_OKAY;
        unique case (r_state)
            RD_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_nextState = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (w_timeout) begin
                    w_nextState = RD_DONE;
                end else if (w_arHandshake) begin
                    w_nextState = RD_DATA;
                end
            end
            RD_DATA: begin
                if (w_timeout) begin
                    w_nextState = RD_DONE;
                end else if (w_rAccept && w_finalBeat) begin
                    w_nextState = RD_DONE;
                end
            end
            RD_DONE: begin
                done_valid  = 1'b1;
                done_resp   = r_status;
                w_nextState = RD_IDLE;
            end
            default: begin
                w_nextState = RD_IDLE;
            end
        endcase
    end

    // Burst bookkeeping: the AR fields are latched at command time and held
    // until arready, the beat counter tracks the expected burst length (it,
    // not rlast, ends the burst), and the status keeps the first error seen.
    // A misplaced rlast only reports SLVERR if nothing worse came first.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_arvalid        <= 1'b0;
            r_araddr         <= '0;
            r_arlen          <= '0;
            r_beatsRemaining <= '0;
            r_status         <= RESP_OKAY;
        end else begin
            if (w_cmdAccept) begin
                r_araddr  <= cmd_addr & ALIGN_MASK;
                r_arlen   <= cmd_len;
                r_arvalid <= 1'b1;
            end else if (w_arHandshake || w_timeout) begin
                r_arvalid <= 1'b0;
            end

            if (w_arHandshake) begin
                r_beatsRemaining <= {1'b0, r_arlen} + 9'd1;
                r_status         <= RESP_OKAY;
            end else if (w_rAccept) begin
                r_beatsRemaining <= r_beatsRemaining - 9'd1;
                if (r_status == RESP_OKAY) begin
                    if (rresp[1]) begin
                        r_status <= rresp;
                    end else if (w_rlastBad) begin
                        r_status <= RESP_SLVERR;
                    end
                end
            end

            if (w_timeout) begin
                r_status <= RESP_DECERR;
            end
        end
    end

    axi_rd_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_outReg (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .i_enable (w_dataPhase),
        .i_data   (rdata),
        .i_last   (w_finalBeat),
        .i_valid  (rvalid),
        .i_ready  (out_ready),
        .o_rready (rready),
        .o_accept (w_rAccept),
        .o_data   (out_data),
        .o_last   (out_last),
        .o_valid  (out_valid)
    );

    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arsize  = AR_SIZE;
    assign arburst = BURST_INCR;
    assign arvalid = r_arvalid;

endmodule

// File: tb/tb_axi_read_master.sv
// -----------------------------------------------------------------------------
// tb_axi_read_master
// Self-checking bench for axi_read_master (default build, 32-bit data, 8-bit
// address). Acts as the AXI slave and the downstream consumer, runs a table of
// directed bursts, a mid-burst reset sequence and a batch of random bursts.
// Inputs are driven 1ns after the rising edge and outputs sampled on the
// falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_read_master;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic [7:0]  araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;

    int checkCount = 0;
    int passCount  = 0;
    int readyMode  = 0;
    bit monOn      = 1'b0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t      gotQ[$];
    logic [1:0] doneQ[$];

    logic [31:0] beatData [8];
    logic [1:0]  beatResp [8];
    logic        beatLast [8];

    typedef struct {
        string       name;
        logic [7:0]  addr;
        logic [7:0]  expAraddr;
        logic [7:0]  len;
        int          arDelay;
        int          readyM;
        int          gapMax;
        logic [31:0] firstData;
        int          errBeatA;
        logic [1:0]  errRespA;
        int          errBeatB;
        logic [1:0]  errRespB;
        int          rlastBeat;
        logic [1:0]  expResp;
    } vec_t;

    vec_t vecs[7];

    always #5 aclk = ~aclk;

    axi_read_master dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .done_valid (done_valid),
        .done_resp  (done_resp),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready)
    );

    // One comparison: counts it, and reports it if it does not match.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference status: the earliest beat carrying either an error response
    // or an rlast in the wrong place decides the burst status; EXOKAY is fine.
    function automatic logic [1:0] modelResp(input int len);
        for (int i = 0; i <= len; i++) begin
            if (beatResp[i] == 2'b10 || beatResp[i] == 2'b11) begin
                return beatResp[i];
            end
            if (beatLast[i] != (i == len)) begin
                return 2'b10;
            end
        end
        return 2'b00;
    endfunction

    // Downstream consumer: out_ready pattern chosen by readyMode
    // (0 = always ready, 1 = toggling, 2 = random).
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: records every output beat and done pulse that will be taken at
    // the next rising edge, and checks that rready backs off under stall.
    initial begin
        forever begin
            @(negedge aclk);
            if (monOn) begin
                if (out_valid && out_ready) begin
                    gotQ.push_back({out_data, out_last});
                end
                if (done_valid) begin
                    doneQ.push_back(done_resp);
                end
                if (out_valid && !out_ready) begin
                    checkOutput("rready_backpressure", 32'(rready), 32'd0);
                end
            end
        end
    end

    // Absolute bound on the whole run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks %0d", checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitArvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (arvalid) begin
                ok = 1'b1;
                break;
            end
            @(posedge aclk);
            #1;
        end
    endtask

    // Runs one complete burst as command source, AXI slave and consumer, then
    // compares the delivered stream and done status with the expectations.
    // Beat contents come from beatData/beatResp/beatLast.
    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] expAraddr,
                                 input logic [7:0] len, input int arDelay,
                                 input int gapMax, input logic [1:0] expResp);
        bit ok;
        bit accepted;
        int nBeats;
        nBeats = int'(len) + 1;
        gotQ.delete();
        doneQ.delete();

        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(negedge aclk);
        checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 8'($urandom);
        cmd_len   = 8'($urandom);

        waitArvalid(ok);
        checkOutput("arvalid_seen", 32'(ok), 32'd1);
        if (!ok) begin
            return;
        end
        checkOutput("araddr", 32'(araddr), 32'(expAraddr));
        checkOutput("arlen", 32'(arlen), 32'(len));
        checkOutput("arsize", 32'(arsize), 32'd2);
        checkOutput("arburst", 32'(arburst), 32'd1);
        @(posedge aclk);
        #1;

        for (int d = 0; d < arDelay; d++) begin
            @(negedge aclk);
            checkOutput("ar_stall_arvalid", 32'(arvalid), 32'd1);
            checkOutput("ar_stall_araddr", 32'(araddr), 32'(expAraddr));
            checkOutput("ar_stall_arlen", 32'(arlen), 32'(len));
            checkOutput("ar_stall_cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge aclk);
            #1;
        end
        arready = 1'b1;
        @(negedge aclk);
        checkOutput("ar_handshake", 32'(arvalid), 32'd1);
        @(posedge aclk);
        #1;
        arready = 1'b0;

        for (int i = 0; i < nBeats; i++) begin
            int gaps;
            gaps   = $urandom_range(0, gapMax);
            rvalid = 1'b0;
            repeat (gaps) begin
                @(posedge aclk);
                #1;
            end
            rvalid   = 1'b1;
            rdata    = beatData[i];
            rresp    = beatResp[i];
            rlast    = beatLast[i];
            accepted = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge aclk);
                if (rready) begin
                    accepted = 1'b1;
                end
                @(posedge aclk);
                #1;
                if (accepted) begin
                    break;
                end
            end
            if (!accepted) begin
                checkOutput("rready_timeout", 32'd0, 32'd1);
                rvalid = 1'b0;
                return;
            end
        end
        rvalid = 1'b0;
        rlast  = 1'b0;

        for (int k = 0; k < 200; k++) begin
            @(negedge aclk);
            if (gotQ.size() >= nBeats && doneQ.size() > 0) begin
                break;
            end
        end
        repeat (3) @(negedge aclk);

        checkOutput("beat_count", 32'(gotQ.size()), 32'(nBeats));
        for (int i = 0; i < nBeats && i < gotQ.size(); i++) begin
            checkOutput("beat_data", gotQ[i].data, beatData[i]);
            checkOutput("beat_last", 32'(gotQ[i].last), 32'(i == nBeats - 1));
        end
        checkOutput("done_pulses", 32'(doneQ.size()), 32'd1);
        if (doneQ.size() > 0) begin
            checkOutput("done_resp", 32'(doneQ[0]), 32'(expResp));
        end
        @(posedge aclk);
        #1;
    endtask

    // Fills the beat arrays for a table entry: incrementing data, optional
    // error responses on two beats and an optional early rlast.
    task automatic loadVector(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            beatData[i] = v.firstData + 32'(i) * 32'h0101_0101;
            beatResp[i] = 2'b00;
            beatLast[i] = (i == int'(v.len)) || (i == v.rlastBeat);
        end
        if (v.errBeatA >= 0) beatResp[v.errBeatA] = v.errRespA;
        if (v.errBeatB >= 0) beatResp[v.errBeatB] = v.errRespB;
    endtask

    initial begin
        bit ok;

        // Directed table: name, addr, expected araddr, len, AR delay, ready
        // mode, R gap max, first data word, error beat/resp A and B,
        // early-rlast beat, expected done status.
        vecs[0] = '{"single",     8'h10, 8'h10, 8'd0, 0, 0, 0, 32'hDEAD_BEEF, -1, 2'b00, -1, 2'b00, -1, 2'b00};
        vecs[1] = '{"toggle4",    8'h20, 8'h20, 8'd3, 0, 1, 0, 32'h1111_0000, -1, 2'b00, -1, 2'b00, -1, 2'b00};
        vecs[2] = '{"ar_stall",   8'h40, 8'h40, 8'd1, 5, 0, 1, 32'hA000_0000, -1, 2'b00, -1, 2'b00, -1, 2'b00};
        vecs[3] = '{"resp_err",   8'h30, 8'h30, 8'd3, 0, 0, 0, 32'h2222_0000,  1, 2'b10,  2, 2'b11, -1, 2'b10};
        vecs[4] = '{"rlast_early",8'h50, 8'h50, 8'd3, 0, 0, 0, 32'h3333_0000, -1, 2'b00, -1, 2'b00,  1, 2'b10};
        vecs[5] = '{"unaligned",  8'h13, 8'h10, 8'd0, 1, 0, 0, 32'h4444_0000, -1, 2'b00, -1, 2'b00, -1, 2'b00};
        vecs[6] = '{"exokay",     8'h64, 8'h64, 8'd2, 0, 2, 1, 32'h5555_0000,  0, 2'b01, -1, 2'b00, -1, 2'b00};

        // Reset state.
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("reset_arvalid", 32'(arvalid), 32'd0);
        checkOutput("reset_rready", 32'(rready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_last", 32'(out_last), 32'd0);
        checkOutput("reset_done_valid", 32'(done_valid), 32'd0);
        checkOutput("reset_done_resp", 32'(done_resp), 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        monOn   = 1'b1;

        // Directed vectors.
        for (int v = 0; v < 7; v++) begin
            $display("[TB] vector %s", vecs[v].name);
            readyMode = vecs[v].readyM;
            loadVector(vecs[v]);
            applyStimulus(vecs[v].addr, vecs[v].expAraddr, vecs[v].len,
                          vecs[v].arDelay, vecs[v].gapMax, vecs[v].expResp);
        end

        // Reset during the data phase of a 4-beat burst, with beat 2 on the bus.
        $display("[TB] mid-burst reset");
        readyMode = 0;
        gotQ.delete();
        doneQ.delete();
        cmd_addr  = 8'h80;
        cmd_len   = 8'd3;
        cmd_valid = 1'b1;
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
        waitArvalid(ok);
        checkOutput("rst_seq_arvalid", 32'(ok), 32'd1);
        @(posedge aclk);
        #1;
        arready = 1'b1;
        @(posedge aclk);
        #1;
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hCAFE_0001;
        rresp   = 2'b00;
        rlast   = 1'b0;
        @(posedge aclk);
        #1;
        rdata   = 32'hCAFE_0002;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        @(negedge aclk);
        checkOutput("midrst_arvalid", 32'(arvalid), 32'd0);
        checkOutput("midrst_rready", 32'(rready), 32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_done_valid", 32'(done_valid), 32'd0);
        @(posedge aclk);
        #1;
        rvalid  = 1'b0;
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("midrst_no_done", 32'(doneQ.size()), 32'd0);
        @(posedge aclk);
        #1;
        beatData[0] = 32'h0BAD_F00D;
        beatResp[0] = 2'b00;
        beatLast[0] = 1'b1;
        applyStimulus(8'h24, 8'h24, 8'd0, 0, 0, 2'b00);

        // Random bursts against the reference model.
        for (int n = 0; n < 20; n++) begin
            logic [7:0] addr;
            logic [7:0] len;
            int         r;
            addr      = 8'($urandom);
            len       = 8'($urandom_range(0, 7));
            readyMode = $urandom_range(0, 2);
            for (int i = 0; i < 8; i++) begin
                beatData[i] = $urandom;
                r = $urandom_range(0, 9);
                beatResp[i] = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
                beatLast[i] = (i == int'(len));
                if ($urandom_range(0, 15) == 0) begin
                    beatLast[i] = ~beatLast[i];
                end
            end
            applyStimulus(addr, addr - (addr % 8'd4), len,
                          $urandom_range(0, 3), $urandom_range(0, 2), modelResp(int'(len)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/axi_read_master.md
Name: axi_read_master

Overview:
AXI4 read-channel initiator: accepts a simple read command (address, length), issues one INCR burst on AR, collects R beats, and streams them out through a valid/ready port.
Pairs with the team's AXI slave RAM as the requesting end of the read path.
One burst in flight at a time; completion status is reported per command.

Parameters:
DATA_WIDTH, 32, R data width in bits
STROBE_WIDTH, DATA_WIDTH/8, bytes per beat
ADDRESS_WIDTH, 8, byte address width
TIMEOUT_CYCLES, 255, watchdog limit (used only with the optional feature)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
cmd_addr  in  ADDRESS_WIDTH  burst start byte address
cmd_len  in  8  beats minus one (AXI encoding)
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when high with cmd_valid
out_data  out  DATA_WIDTH  beat data
out_last  out  1  final beat of burst
out_valid  out  1  out_data valid
out_ready  in  1  downstream ready
done_valid  out  1  one-cycle completion pulse
done_resp  out  2  burst status (OKAY 00, SLVERR 10, DECERR 11)
araddr  out  ADDRESS_WIDTH  AR address
arlen  out  8  AR length
arsize  out  3  AR size
arburst  out  2  AR burst type
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  DATA_WIDTH  R data
rresp  in  2  R response
rlast  in  1  R last
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Reset (aclk, aresetn synchronous active-low): state IDLE; arvalid, rready, out_valid, done_valid = 0; done_resp = 00; out_last = 0. Reset mid-burst abandons the burst with no done pulse.
- States: IDLE, ADDR, DATA, DONE.
- IDLE: cmd_ready = 1. On cmd_valid, latch addr/len and go to ADDR. cmd_ready = 0 in all other states.
- ADDR: arvalid = 1.
  - araddr = latched address with low log2(STROBE_WIDTH) bits forced to 0.
  - arlen = latched len; arsize = log2(STROBE_WIDTH); arburst = 01 (INCR).
  - All AR outputs are registered and stay stable until arready.
  - On arvalid and arready, go to DATA and set beats_remaining (9-bit) = len+1. Clear the status accumulator to 00.
- DATA: rready = !out_valid || out_ready. This is a single-entry output register.
  - On rvalid and rready: out_data <= rdata; out_last <= (beats_remaining==1); out_valid <= 1; decrement beats_remaining.
  - An out_valid and out_ready handshake in the same cycle as a new beat is accepted, so back-to-back throughput is 1 beat/cycle.
- Status: the first non-OKAY rresp is latched and is not overwritten. EXOKAY (01) is treated as OKAY.
- rlast mismatch: rlast high on a non-final beat, or low on the final beat, latches SLVERR if status is still OKAY. The burst always terminates on the expected beat count.
- After the final beat is accepted, go to DONE. DONE lasts one cycle: done_valid = 1, done_resp = status, then return to IDLE.
- The output register may still hold the last beat when IDLE is re-entered. The next burst's beats are back-pressured by rready.
- rready = 0 outside DATA. rvalid in IDLE/ADDR is ignored.
- No 4 KB or address-wrap splitting: araddr + burst overflow past 2**ADDRESS_WIDTH is the slave's concern.

Optional Feature:
AXI_READ_MASTER_TIMEOUT_EN:
- Defined: an 8+ bit counter increments each cycle in ADDR or DATA with no AR or R handshake, and clears on any handshake.
  - On reaching TIMEOUT_CYCLES, drop arvalid/rready and go to DONE with done_resp = 11 (DECERR).
- Undefined: no counter; the master waits indefinitely.

Decomposition:
- Shared package axi_pkg: burst type constants (FIXED 00, INCR 01, WRAP 10), response codes (OKAY, EXOKAY, SLVERR, DECERR), read-master state encoding, clog2 helper for arsize.
- One sub-module: axi_rd_out_reg, the single-entry valid/ready output register that generates rready.

Test Plan:
- cmd_addr=0x10, cmd_len=0; slave returns 0xDEADBEEF, rlast=1, OKAY -> araddr=0x10, arlen=0, arsize=2, arburst=01; out_data=0xDEADBEEF, out_last=1; done_resp=00, one-cycle pulse.
- cmd_len=3, out_ready toggling 1/0 each cycle -> 4 beats delivered in order; only beat 4 has out_last=1; rready low whenever out_valid=1 and out_ready=0; no beat lost or duplicated.
- arready held low for 5 cycles -> arvalid, araddr, arlen stable all 5 cycles; cmd_ready stays 0.
- cmd_len=3, beat 2 rresp=10, beat 3 rresp=11 -> all 4 beats delivered; done_resp=10.
- cmd_len=3, rlast asserted on beat 2 -> 4 beats still consumed; done_resp=10. Separately, cmd_addr=0x13 -> araddr=0x10.
- aresetn low mid-DATA (beat 2 of 4) -> next cycle arvalid=rready=out_valid=done_valid=0; after release, cmd_ready=1 and a new len=0 command completes normally.
